ysyx_22050710_sram_arb: RTL and testbench
=========================================

Name: ysyx_22050710_sram_arb

Overview:
Two-requester arbiter sharing one unified single-port SRAM (1-cycle read latency) between the instruction fetch stage and the memory (load/store) stage. It grants at most one access per cycle and routes the read data back to the requester that issued the access. Priority is fixed (MEM over IF) with a starvation counter that guarantees forward progress for IF. Sits between the IF/MEM stages and the top-level SRAM interface.

Parameters:
SRAM_ADDR_WD, 32, SRAM byte address width
SRAM_DATA_WD, 64, SRAM data width; byte-mask width = SRAM_DATA_WD/8
STARVE_MAX, 4, consecutive IF denials before IF is forced to win (1..15)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-low (0 = reset)
i_if_req  in  1  IF read request; held stable until granted
i_if_addr  in  SRAM_ADDR_WD  IF read address
o_if_gnt  out  1  IF access issued to SRAM this cycle
o_if_rvalid  out  1  o_if_rdata valid (cycle after IF grant)
o_if_rdata  out  SRAM_DATA_WD  IF read data
i_mem_req  in  1  MEM request; held stable until granted
i_mem_wen  in  1  1 = write, 0 = read
i_mem_wmask  in  SRAM_DATA_WD/8  byte write enables
i_mem_addr  in  SRAM_ADDR_WD  MEM address
i_mem_wdata  in  SRAM_DATA_WD  MEM write data
o_mem_gnt  out  1  MEM access issued to SRAM this cycle
o_mem_rvalid  out  1  o_mem_rdata valid (cycle after MEM read grant)
o_mem_rdata  out  SRAM_DATA_WD  MEM read data
o_sram_en  out  1  SRAM access enable
o_sram_wen  out  1  SRAM write enable
o_sram_wmask  out  SRAM_DATA_WD/8  SRAM byte mask
o_sram_addr  out  SRAM_ADDR_WD  SRAM address
o_sram_wdata  out  SRAM_DATA_WD  SRAM write data
i_sram_rdata  in  SRAM_DATA_WD  SRAM read data, valid one cycle after en with wen=0

Behaviour:
- Grant is combinational, same cycle as request; SRAM outputs driven combinationally from the winner; no grant -> o_sram_en=0, wen=0, wmask=0, addr/wdata=0.
- Arbitration: if only one requests, it wins. If both request: MEM wins unless starve_cnt == STARVE_MAX, then IF wins.
- starve_cnt (registered, width ceil(log2(STARVE_MAX+1))): +1 each cycle IF requests and MEM is granted; clears when IF granted or i_if_req=0; saturates at STARVE_MAX (never wraps).
- IF accesses are always reads (wen=0, wmask=0).
- Response owner register resp_own in {NONE, IF, MEM}: next = IF on IF grant, MEM on MEM read grant, NONE otherwise (including MEM write).
- Cycle N+1 after a read grant: rvalid of resp_own asserted for exactly one cycle, its rdata = i_sram_rdata; the other rdata = 0. Back-to-back grants every cycle supported; response for grant N and issue of grant N+1 overlap.
- MEM writes produce no rvalid; o_mem_gnt is the write acknowledge.
- o_if_gnt and o_mem_gnt never both 1; gnt only when corresponding req=1.
- Reset (async assert): starve_cnt=0, resp_own=NONE; all outputs 0 while i_rst=0 (gnts, rvalids, rdata, SRAM outputs). An in-flight read whose response cycle coincides with or follows reset assertion is dropped; no rvalid after deassertion until a new grant.
- Requests dropped before grant are not tracked; requester may change address only after grant.

Test Plan:
- IF-only: i_if_req=1, addr=0x80000000 -> o_if_gnt=1, o_sram_en=1, addr 0x80000000, wen=0; next cycle o_if_rvalid=1, o_if_rdata=SRAM word.
- Contention: both req continuous, STARVE_MAX=4 -> grants MEM,MEM,MEM,MEM,IF repeating; starve_cnt 0..4 then 0; never both gnt.
- MEM write: wen=1, wmask=0x0F, addr 0x80000008, wdata=0x1122334455667788 -> SRAM sees same in grant cycle; no rvalid next cycle; subsequent MEM read same addr returns low 4 bytes updated.
- Back-to-back: IF grant cycle 0, MEM read cycle 1, IF cycle 2 -> rvalids IF@1, MEM@2, IF@3, each rdata matching its issued address.
- Reset mid-read: grant IF read, assert i_rst=0 before next edge -> all outputs 0 immediately; after release no o_if_rvalid without a new request.
- Starvation release: IF req held, MEM req drops at cycle 2 -> IF granted cycle 2, starve_cnt back to 0.

Source files
------------

// File: rtl/ysyx_22050710_sram_arb.sv
// Fixed-priority (MEM over IF) arbiter for one single-port SRAM with 1-cycle read latency.
// IF is guaranteed progress by a saturating starvation counter; read data is routed to the issuer.
module ysyx_22050710_sram_arb #(
    parameter int SRAM_ADDR_WD = 32,
    parameter int SRAM_DATA_WD = 64,
    parameter int STARVE_MAX   = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_if_req,
    input  logic [SRAM_ADDR_WD-1:0]   i_if_addr,
    output logic                      o_if_gnt,
    output logic                      o_if_rvalid,
    output logic [SRAM_DATA_WD-1:0]   o_if_rdata,
    input  logic                      i_mem_req,
    input  logic                      i_mem_wen,
    input  logic [SRAM_DATA_WD/8-1:0] i_mem_wmask,
    input  logic [SRAM_ADDR_WD-1:0]   i_mem_addr,
    input  logic [SRAM_DATA_WD-1:0]   i_mem_wdata,
    output logic                      o_mem_gnt,
    output logic                      o_mem_rvalid,
    output logic [SRAM_DATA_WD-1:0]   o_mem_rdata,
    output logic                      o_sram_en,
    output logic                      o_sram_wen,
    output logic [SRAM_DATA_WD/8-1:0] o_sram_wmask,
    output logic [SRAM_ADDR_WD-1:0]   o_sram_addr,
    output logic [SRAM_DATA_WD-1:0]   o_sram_wdata,
    input  logic [SRAM_DATA_WD-1:0]   i_sram_rdata
);
    localparam int MASK_WD = SRAM_DATA_WD / 8;
    localparam int CNT_WD  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } own_e;

    own_e              resp_own, resp_own_nxt;
    logic [CNT_WD-1:0] starve_cnt, starve_cnt_nxt;
    logic              starved, if_win, mem_win, mem_wr;

    // Grants are forced low while reset is held so no access leaks out.
    assign starved = (starve_cnt == CNT_WD'(STARVE_MAX));
    assign if_win  = i_rst & i_if_req & (~i_mem_req | starved);
    assign mem_win = i_rst & i_mem_req & ~if_win;
    assign mem_wr  = mem_win & i_mem_wen;

    assign o_if_gnt     = if_win;
    assign o_mem_gnt    = mem_win;
    assign o_sram_en    = if_win | mem_win;
    assign o_sram_wen   = mem_wr;
    assign o_sram_wmask = mem_wr ? i_mem_wmask : {MASK_WD{1'b0}};
    assign o_sram_addr  = if_win  ? i_if_addr  :
                          mem_win ? i_mem_addr : {SRAM_ADDR_WD{1'b0}};
    assign o_sram_wdata = mem_win ? i_mem_wdata : {SRAM_DATA_WD{1'b0}};

    assign o_if_rvalid  = (resp_own == OWN_IF);
    assign o_mem_rvalid = (resp_own == OWN_MEM);
    assign o_if_rdata   = o_if_rvalid  ? i_sram_rdata : {SRAM_DATA_WD{1'b0}};
    assign o_mem_rdata  = o_mem_rvalid ? i_sram_rdata : {SRAM_DATA_WD{1'b0}};

    always_comb begin
        resp_own_nxt   = OWN_NONE;
        starve_cnt_nxt = starve_cnt;
        if (if_win)
            resp_own_nxt = OWN_IF;
        else if (mem_win && !i_mem_wen)
            resp_own_nxt = OWN_MEM;
        // Counts only cycles where IF waits behind MEM; saturates rather than wrapping.
        if (!i_if_req || if_win)
            starve_cnt_nxt = '0;
        else if (mem_win && !starved)
            starve_cnt_nxt = starve_cnt + CNT_WD'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            resp_own   <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            resp_own   <= resp_own_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_sram_arb.sv
// Bench for ysyx_22050710_sram_arb: directed scenarios plus random traffic against a
// transaction-level model (winner rule, starvation count, expected read data from a shadow memory).
module tb_ysyx_22050710_sram_arb;
    localparam int AW = 32, DW = 64, MW = DW / 8, SMAX = 4;

    logic          i_clk = 1'b0, i_rst = 1'b0;
    logic          i_if_req = 1'b0, i_mem_req = 1'b0, i_mem_wen = 1'b0;
    logic [AW-1:0] i_if_addr = '0, i_mem_addr = '0;
    logic [MW-1:0] i_mem_wmask = '0;
    logic [DW-1:0] i_mem_wdata = '0, i_sram_rdata = '0;
    logic          o_if_gnt, o_if_rvalid, o_mem_gnt, o_mem_rvalid, o_sram_en, o_sram_wen;
    logic [DW-1:0] o_if_rdata, o_mem_rdata, o_sram_wdata;
    logic [MW-1:0] o_sram_wmask;
    logic [AW-1:0] o_sram_addr;

    always #5 i_clk = ~i_clk;

    ysyx_22050710_sram_arb #(.SRAM_ADDR_WD(AW), .SRAM_DATA_WD(DW), .STARVE_MAX(SMAX)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_mem_req(i_mem_req), .i_mem_wen(i_mem_wen), .i_mem_wmask(i_mem_wmask),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .o_mem_gnt(o_mem_gnt),
        .o_mem_rvalid(o_mem_rvalid), .o_mem_rdata(o_mem_rdata),
        .o_sram_en(o_sram_en), .o_sram_wen(o_sram_wen), .o_sram_wmask(o_sram_wmask),
        .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a, ~a} ^ 64'h5a5a_c3c3_0ff0_9669;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r = o;
        for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // SRAM device driven by the DUT's SRAM port; garbage on the data bus when no read was issued.
    logic [DW-1:0] sram_mem [logic [AW-1:0]];
    function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : init_word(a);
    endfunction
    always @(posedge i_clk) begin
        if (o_sram_en && !o_sram_wen) i_sram_rdata <= sram_rd(o_sram_addr);
        else                          i_sram_rdata <= {$urandom, $urandom};
        if (o_sram_en && o_sram_wen)
            sram_mem[o_sram_addr] = merge(sram_rd(o_sram_addr), o_sram_wdata, o_sram_wmask);
    end

    // Reference model state: starvation count, pending response owner (0 none, 1 IF, 2 MEM).
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            starve = 0, pend = 0;
    logic [DW-1:0] pend_data = '0;
    logic          if_hold = 1'b0, mem_hold = 1'b0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return 32'h8000_0000 + AW'($urandom_range(0, 7) * 8);
    endfunction

    // Called at a falling edge once inputs are set; checks this cycle and advances the model.
    task automatic check_cycle();
        logic e_if, e_mem;
        #1;
        e_if  = i_if_req && (!i_mem_req || starve == SMAX);
        e_mem = i_mem_req && !e_if;
        chk("if_gnt", DW'(o_if_gnt), DW'(e_if));
        chk("mem_gnt", DW'(o_mem_gnt), DW'(e_mem));
        chk("if_rvalid", DW'(o_if_rvalid), DW'(pend == 1));
        chk("if_rdata", o_if_rdata, (pend == 1) ? pend_data : '0);
        chk("mem_rvalid", DW'(o_mem_rvalid), DW'(pend == 2));
        chk("mem_rdata", o_mem_rdata, (pend == 2) ? pend_data : '0);
        chk("sram_en", DW'(o_sram_en), DW'(e_if || e_mem));
        chk("sram_wen", DW'(o_sram_wen), DW'(e_mem && i_mem_wen));
        chk("sram_wmask", DW'(o_sram_wmask), (e_mem && i_mem_wen) ? DW'(i_mem_wmask) : '0);
        chk("sram_addr", DW'(o_sram_addr), e_if ? DW'(i_if_addr) : e_mem ? DW'(i_mem_addr) : '0);
        chk("sram_wdata", o_sram_wdata, e_mem ? i_mem_wdata : '0);
        pend = 0;
        if (e_if) begin
            pend = 1; pend_data = ref_rd(i_if_addr);
        end else if (e_mem && i_mem_wen) begin
            ref_mem[i_mem_addr] = merge(ref_rd(i_mem_addr), i_mem_wdata, i_mem_wmask);
        end else if (e_mem) begin
            pend = 2; pend_data = ref_rd(i_mem_addr);
        end
        if (!i_if_req || e_if) starve = 0;
        else if (e_mem && starve < SMAX) starve++;
        if_hold  = i_if_req && !e_if;
        mem_hold = i_mem_req && !e_mem;
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_if_gnt"}, DW'(o_if_gnt), '0);
        chk({tag, "_mem_gnt"}, DW'(o_mem_gnt), '0);
        chk({tag, "_if_rvalid"}, DW'(o_if_rvalid), '0);
        chk({tag, "_mem_rvalid"}, DW'(o_mem_rvalid), '0);
        chk({tag, "_if_rdata"}, o_if_rdata, '0);
        chk({tag, "_mem_rdata"}, o_mem_rdata, '0);
        chk({tag, "_sram_en"}, DW'(o_sram_en), '0);
        chk({tag, "_sram_wen"}, DW'(o_sram_wen), '0);
        chk({tag, "_sram_wmask"}, DW'(o_sram_wmask), '0);
        chk({tag, "_sram_addr"}, DW'(o_sram_addr), '0);
        chk({tag, "_sram_wdata"}, o_sram_wdata, '0);
    endtask

    task automatic drive(input logic ifr, input logic [AW-1:0] ia, input logic mr, input logic wen,
                         input logic [MW-1:0] wm, input logic [AW-1:0] ma, input logic [DW-1:0] wd);
        @(negedge i_clk);
        i_if_req = ifr; i_if_addr = ia; i_mem_req = mr; i_mem_wen = wen;
        i_mem_wmask = wm; i_mem_addr = ma; i_mem_wdata = wd;
        check_cycle();
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        // Outputs stay low under reset even with both requesters active.
        i_if_req = 1'b1; i_if_addr = 32'h8000_0000; i_mem_req = 1'b1; i_mem_addr = 32'h8000_0008;
        i_mem_wen = 1'b1; i_mem_wmask = '1; i_mem_wdata = 64'hdead_beef_0000_1111;
        #3 zero_check("rst");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        i_if_req = 1'b0; i_mem_req = 1'b0;

        // IF-only read
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, '0, '0, '0);
        idle();

        // MEM write then read back the same word
        drive(1'b0, '0, 1'b1, 1'b1, 8'h0F, 32'h8000_0008, 64'h1122_3344_5566_7788);
        drive(1'b0, '0, 1'b1, 1'b0, '0, 32'h8000_0008, '0);
        idle();
        chk("wr_readback_lo", DW'(o_mem_rdata[31:0]), DW'(32'h5566_7788));

        // Back-to-back IF, MEM read, IF
        drive(1'b1, 32'h8000_0010, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, '0, 32'h8000_0018, '0);
        drive(1'b1, 32'h8000_0020, 1'b0, 1'b0, '0, '0, '0);
        idle();

        // Continuous contention: MEM x4 then IF, repeating
        for (int c = 0; c < 15; c++)
            drive(1'b1, 32'h8000_0028, 1'b1, 1'b0, '0, 32'h8000_0030, '0);
        idle();

        // Starvation release when MEM drops its request
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, '0, 32'h8000_0008, '0);
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, '0, 32'h8000_0010, '0);
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 32'h8000_0018, 1'b1, 1'b0, '0, 32'h8000_0020, '0);
        idle();

        // Reset arriving while an IF read is in flight
        drive(1'b1, 32'h8000_0038, 1'b0, 1'b0, '0, '0, '0);
        #2 i_rst = 1'b0;
        #1 zero_check("rst_mid");
        starve = 0; pend = 0; if_hold = 1'b0; mem_hold = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1; i_if_req = 1'b0;
        check_cycle();
        idle();

        // Random traffic; ungranted requests are held stable
        for (int c = 0; c < 1500; c++) begin
            @(negedge i_clk);
            if (!if_hold) begin
                i_if_req  = ($urandom_range(0, 3) != 0);
                i_if_addr = rand_addr();
            end
            if (!mem_hold) begin
                i_mem_req   = ($urandom_range(0, 3) != 0);
                i_mem_wen   = ($urandom_range(0, 2) == 0);
                i_mem_wmask = MW'($urandom);
                i_mem_addr  = rand_addr();
                i_mem_wdata = {$urandom, $urandom};
            end
            check_cycle();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
